calc_op_sequencer: RTL
======================

Name: calc_op_sequencer

Overview:
Parametrised next-generation controller for the button-driven calculator datapath. It accepts a one-hot operation request, issues an encoded op-select with a start/done handshake to a multi-cycle ALU, loads the result, and drives the 7-segment display-enable blink pattern from internal timers instead of external comparator flags. Adds a divide-by-zero error path, a new-request interrupt during blinking, and button re-arm.

Parameters:
NUM_OPS, 4, number of operation buttons (2..16)
SEL_W, $clog2(NUM_OPS), op_sel width (derived, not overridden)
ON_CYCLES, 50, display-on cycles per blink period (>=1)
PERIOD_CYCLES, 200, full blink period in cycles (>ON_CYCLES)
TIMEOUT_CYCLES, 1024, op_done watchdog limit (used only with OP_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
button  in  NUM_OPS  debounced op request, one-hot; bit i selects op i
op_done  in  1  ALU result valid, single-cycle pulse
div_zero  in  1  ALU error flag, sampled with op_done
load_inputs  out  1  latch operand registers
reg_clr  out  1  clear result register
op_start  out  1  single-cycle ALU start pulse
op_sel  out  SEL_W  encoded op index, held stable from START until next request
ld  out  1  load result register
display  out  1  display enable (blink)
busy  out  1  high from START through LOAD
err  out  1  sticky error indicator

Behaviour:
- Reset (reset=0, async): state INIT; all outputs 0 except display=1; op_sel=0; timers 0; armed=1.
- States: INIT, IDLE, START, EXEC, LOAD, SHOW, BLANK, ERROR.
- INIT: reg_clr=1, load_inputs=1 for one cycle -> IDLE.
- IDLE/SHOW/BLANK/ERROR: a request is valid when armed=1 and button is exactly one-hot; zero or multi-hot ignored. Valid request -> START, op_sel registered to index of set bit, armed cleared. armed re-sets only when button==0 is sampled.
- START: op_start=1, busy=1, err cleared -> EXEC.
- EXEC: busy=1; wait for op_done. op_done & ~div_zero -> LOAD; op_done & div_zero -> ERROR (err=1). Buttons ignored.
- LOAD: ld=1, busy=1 for one cycle; blink counter cleared -> SHOW.
- SHOW: display=1; counter increments; at count ON_CYCLES-1 -> BLANK.
- BLANK: display=0; counter continues; at count PERIOD_CYCLES-1 -> counter 0, SHOW. Blinking repeats indefinitely.
- ERROR: display alternates on/off every ON_CYCLES (fast blink); err=1 until next START.
- Latency: valid request to op_start = 1 cycle; op_done to ld = 1 cycle; ld to first display drop = ON_CYCLES+1 cycles.
- Simultaneous: valid request in SHOW/BLANK wins over timer transition; op_done same cycle as a button press -> button ignored (EXEC).
- Reset mid-EXEC: returns to INIT; ALU must tolerate an abandoned op.
- Counter width $clog2(PERIOD_CYCLES); no wrap past PERIOD_CYCLES-1.

Optional Feature:
OP_TIMEOUT_EN: when defined, a watchdog counts cycles in EXEC; reaching TIMEOUT_CYCLES without op_done -> ERROR, err=1. When undefined, EXEC waits indefinitely and TIMEOUT_CYCLES is unused.

Decomposition:
- Package calc_pkg: state enum type, helper function for one-hot-to-index with validity flag.
- Sub-module calc_blink_timer: counter with clear, enable, ON/PERIOD parameters; outputs on_done, period_done.

Test Plan:
- NUM_OPS=4, ON=5, PERIOD=20: release reset -> reg_clr and load_inputs high exactly one cycle, then IDLE with display=1.
- button=4'b0100 -> op_start next cycle, op_sel=2, busy=1; op_done after 7 cycles -> ld one cycle later, busy drops after LOAD.
- After LOAD: display high 5 cycles, low 15, repeats 3 periods; button=4'b0001 mid-BLANK (after release) -> START with op_sel=0, display=1.
- button=4'b0011 or held 4'b1000 without release -> no op_start; release then press 4'b1000 -> op_sel=3.
- op_done with div_zero=1 -> err=1, display toggles every 5 cycles; next valid request clears err at START.
- OP_TIMEOUT_EN, TIMEOUT=64: no op_done -> ERROR at cycle 64 of EXEC; reset low mid-EXEC -> immediate INIT, all outputs at reset values.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared state encoding and one-hot request decoding for calc_op_sequencer
package calc_pkg;

    localparam int MAX_OPS = 16;
    localparam int IDX_W   = 4;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_START,
        ST_EXEC,
        ST_LOAD,
        ST_SHOW,
        ST_BLANK,
        ST_ERROR
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } onehot_t;

    // valid only when exactly one bit is set; idx is that bit's position
    function automatic onehot_t onehot_decode(input logic [MAX_OPS-1:0] vec);
        onehot_t     res;
        int unsigned cnt;
        res = '0;
        cnt = 0;
        for (int i = 0; i < MAX_OPS; i++) begin
            if (vec[i]) begin
                cnt++;
                res.idx = IDX_W'(i);
            end
        end
        res.valid = (cnt == 1);
        return res;
    endfunction

endpackage

// File: rtl/calc_blink_timer.sv
// rtl/calc_blink_timer.sv - blink period counter flagging end of on-phase and end of period
module calc_blink_timer #(
    parameter int ON_CYCLES     = 50,
    parameter int PERIOD_CYCLES = 200
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_on_done,
    output logic o_period_done
);

    localparam int CNT_W = $clog2(PERIOD_CYCLES);

    logic [CNT_W-1:0] r_cnt;

    assign o_on_done     = (r_cnt == CNT_W'(ON_CYCLES - 1));
    assign o_period_done = (r_cnt == CNT_W'(PERIOD_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_period_done ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/calc_op_sequencer.sv
// rtl/calc_op_sequencer.sv - calculator op sequencer: request arming, ALU handshake, result blink
// Optional EXEC watchdog enabled by defining OP_TIMEOUT_EN.
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int NUM_OPS        = 4,
    parameter int ON_CYCLES      = 50,
    parameter int PERIOD_CYCLES  = 200,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int SEL_W         = $clog2(NUM_OPS)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_OPS-1:0] i_button,
    input  logic               i_op_done,
    input  logic               i_div_zero,
    output logic               o_load_inputs,
    output logic               o_reg_clr,
    output logic               o_op_start,
    output logic [SEL_W-1:0]   o_op_sel,
    output logic               o_ld,
    output logic               o_display,
    output logic               o_busy,
    output logic               o_err
);

    state_t             r_state;
    logic               r_load_inputs;
    logic               r_reg_clr;
    logic               r_op_start;
    logic [SEL_W-1:0]   r_op_sel;
    logic               r_ld;
    logic               r_display;
    logic               r_busy;
    logic               r_err;
    logic               r_armed;

    onehot_t            w_dec;
    logic               w_req;
    logic               w_tmr_clr;
    logic               w_tmr_en;
    logic               w_on_done;
    logic               w_period_done;
    logic               w_timeout;

    assign w_dec = onehot_decode(16'(i_button));
    assign w_req = r_armed && w_dec.valid;

    // ERROR reuses the timer as a half-period counter, restarting it at each toggle
    assign w_tmr_clr = (r_state == ST_START) || (r_state == ST_LOAD) ||
                       ((r_state == ST_ERROR) && w_on_done);
    assign w_tmr_en  = (r_state == ST_SHOW) || (r_state == ST_BLANK) || (r_state == ST_ERROR);

    calc_blink_timer #(
        .ON_CYCLES     (ON_CYCLES),
        .PERIOD_CYCLES (PERIOD_CYCLES)
    ) u_blink_timer (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_clr         (w_tmr_clr),
        .i_en          (w_tmr_en),
        .o_on_done     (w_on_done),
        .o_period_done (w_period_done)
    );

`ifdef OP_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDOG_W-1:0] r_wdog;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wdog <= '0;
        end else if (r_state == ST_START) begin
            r_wdog <= '0;
        end else if (r_state == ST_EXEC) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    assign w_timeout = (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_INIT;
            r_load_inputs <= 1'b0;
            r_reg_clr     <= 1'b0;
            r_op_start    <= 1'b0;
            r_op_sel      <= '0;
            r_ld          <= 1'b0;
            r_display     <= 1'b1;
            r_busy        <= 1'b0;
            r_err         <= 1'b0;
            r_armed       <= 1'b1;
        end else begin
            r_load_inputs <= 1'b0;
            r_reg_clr     <= 1'b0;
            r_op_start    <= 1'b0;
            r_ld          <= 1'b0;
            if (i_button == '0) begin
                r_armed <= 1'b1;
            end
            case (r_state)
                ST_INIT: begin
                    r_reg_clr     <= 1'b1;
                    r_load_inputs <= 1'b1;
                    r_state       <= ST_IDLE;
                end
                ST_START: r_state <= ST_EXEC;
                ST_EXEC: begin
                    if (i_op_done && !i_div_zero) begin
                        r_ld    <= 1'b1;
                        r_state <= ST_LOAD;
                    end else if (i_op_done || w_timeout) begin
                        r_err     <= 1'b1;
                        r_busy    <= 1'b0;
                        r_display <= 1'b1;
                        r_state   <= ST_ERROR;
                    end
                end
                ST_LOAD: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_SHOW;
                end
                ST_IDLE, ST_SHOW, ST_BLANK, ST_ERROR: begin
                    // a new request pre-empts any blink transition due this cycle
                    if (w_req) begin
                        r_op_start <= 1'b1;
                        r_op_sel   <= SEL_W'(w_dec.idx);
                        r_busy     <= 1'b1;
                        r_err      <= 1'b0;
                        r_display  <= 1'b1;
                        r_armed    <= 1'b0;
                        r_state    <= ST_START;
                    end else if (r_state == ST_SHOW && w_on_done) begin
                        r_display <= 1'b0;
                        r_state   <= ST_BLANK;
                    end else if (r_state == ST_BLANK && w_period_done) begin
                        r_display <= 1'b1;
                        r_state   <= ST_SHOW;
                    end else if (r_state == ST_ERROR && w_on_done) begin
                        r_display <= ~r_display;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign o_load_inputs = r_load_inputs;
    assign o_reg_clr     = r_reg_clr;
    assign o_op_start    = r_op_start;
    assign o_op_sel      = r_op_sel;
    assign o_ld          = r_ld;
    assign o_display     = r_display;
    assign o_busy        = r_busy;
    assign o_err         = r_err;

endmodule
